// File: rtl/crc32_pkg.sv
// crc32_pkg
// Shared constants and the single-bit CRC step for the CRC-32/BZIP2 stream engine.
//   CRC32_POLY    generator polynomial (MSB-first form)
//   CRC32_INIT    register value at the start of every frame
//   CRC32_RESIDUE register value left after a frame that ends with its own valid FCS
//   crc32_bit()   one serial step: feedback = crc[31] ^ data bit, shift left, conditional XOR
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic data_bit);
    logic fb;
    fb = crc[31] ^ data_bit;
    return {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// crc32_stream_if
// Beat stream into the CRC engine and the per-frame result coming back out.
//   axiiv/axiid/axiil  beat valid, beat data (bit 0 first), last beat of frame
//   axiov              one-cycle frame result strobe
//   axiod/axiol        final CRC and frame length in beats, held until the next result
//   fcs_ok             FCS residue check result, held with axiod
// Modports: master drives beats and observes results; slave is the CRC engine.
interface crc32_stream_if #(
  parameter int DATA_W = 2,
  parameter int LEN_W  = 16
);

  logic              axiiv;
  logic [DATA_W-1:0] axiid;
  logic              axiil;
  logic              axiov;
  logic [31:0]       axiod;
  logic [LEN_W-1:0]  axiol;
  logic              fcs_ok;

  modport master (
    output axiiv, axiid, axiil,
    input  axiov, axiod, axiol, fcs_ok
  );

  modport slave (
    input  axiiv, axiid, axiil,
    output axiov, axiod, axiol, fcs_ok
  );

endinterface

// File: rtl/crc32_comb.sv
// crc32_comb
// Purely combinational CRC-32 update for one beat: applies DATA_W serial steps,
// consuming data[0] first.
//   crc_in   register value before the beat
//   data     beat data
//   crc_out  register value after the beat
module crc32_comb
  import crc32_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_out
);

  // Unrolled chain of serial steps, lowest data bit first
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      crc_out = crc32_bit(crc_out, data[i]);
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream
// Frame-aware CRC-32/BZIP2 engine. Accumulates a CRC over every valid beat; on the
// last beat of a frame it publishes the inverted CRC, the beat count and the FCS
// residue check one cycle later, then re-arms for the next frame in the same edge.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset; discards any partial frame
//   bus  crc32_stream_if slave: axiiv/axiid/axiil in, axiov/axiod/axiol/fcs_ok out
// Build option: define CRC32_STREAM_CHECK_EN to build the residue comparator;
// without it fcs_ok is constant 0.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int LEN_W  = 16
) (
  input logic           clk,
  input logic           rst,
  crc32_stream_if.slave bus
);

  logic [31:0]      crc_r;
  logic [LEN_W-1:0] cnt_r;
  logic             axiov_r;
  logic [31:0]      axiod_r;
  logic [LEN_W-1:0] axiol_r;
  logic             fcs_ok_r;

  logic [31:0]      crc_next_s;
  logic [LEN_W-1:0] cnt_inc_s;
  logic             fcs_hit_s;

  crc32_comb #(
    .DATA_W (DATA_W)
  ) u_comb (
    .crc_in  (crc_r),
    .data    (bus.axiid),
    .crc_out (crc_next_s)
  );

  // Beat counter holds at all-ones so very long frames report the maximum length
  assign cnt_inc_s = (cnt_r == {LEN_W{1'b1}}) ? cnt_r : cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};

`ifdef CRC32_STREAM_CHECK_EN
  // A frame carrying its own correct FCS leaves the fixed residue in the register
  assign fcs_hit_s = (crc_next_s == CRC32_RESIDUE);
`else
  assign fcs_hit_s = 1'b0;
`endif

  // CRC accumulator, beat counter and held frame result
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r    <= CRC32_INIT;
      cnt_r    <= {LEN_W{1'b0}};
      axiov_r  <= 1'b0;
      axiod_r  <= 32'h0000_0000;
      axiol_r  <= {LEN_W{1'b0}};
      fcs_ok_r <= 1'b0;
    end else if (bus.axiiv && bus.axiil) begin
      // Publish the result including this beat and restart from INIT for a gapless next frame
      crc_r    <= CRC32_INIT;
      cnt_r    <= {LEN_W{1'b0}};
      axiov_r  <= 1'b1;
      axiod_r  <= ~crc_next_s;
      axiol_r  <= cnt_inc_s;
      fcs_ok_r <= fcs_hit_s;
    end else if (bus.axiiv) begin
      crc_r    <= crc_next_s;
      cnt_r    <= cnt_inc_s;
      axiov_r  <= 1'b0;
    end else begin
      axiov_r  <= 1'b0;
    end
  end

  assign bus.axiov  = axiov_r;
  assign bus.axiod  = axiod_r;
  assign bus.axiol  = axiol_r;
  assign bus.fcs_ok = fcs_ok_r;

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream
// Self-checking bench for crc32_stream. Two instances: DATA_W=8/LEN_W=4 (byte frames,
// length saturation at 15) and DATA_W=2/LEN_W=16 (dibit frames with idle gaps).
// Expected results are queued when a last beat is driven and compared when axiov fires.
module tb_crc32_stream;

  localparam logic [31:0] POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] RES   = 32'hC704_DD7B;
  localparam logic [31:0] CHECK = 32'hFC89_1918;

`ifdef CRC32_STREAM_CHECK_EN
  localparam bit EXP_CHK = 1'b1;
`else
  localparam bit EXP_CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] crc;
    logic [15:0] len;
    logic        fcs;
  } exp_t;

  typedef struct {
    logic [191:0] data;
    int           nbytes;
    bit           use_model;
    logic [31:0]  crc;
    logic [15:0]  len;
    logic         fcs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   pulses2 = 0;
  exp_t q8[$];
  exp_t q2[$];
  int   pc8[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  // Free-running cycle count for pulse spacing checks
  always @(posedge clk) cyc <= cyc + 1;

  crc32_stream_if #(.DATA_W(8), .LEN_W(4))  bus8 ();
  crc32_stream_if #(.DATA_W(2), .LEN_W(16)) bus2 ();

  crc32_stream #(.DATA_W(8), .LEN_W(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  crc32_stream #(.DATA_W(2), .LEN_W(16)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: raw register after feeding bytes MSB first from INIT
  function automatic logic [31:0] model_reg(input logic [191:0] d, input int n);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = d[i*8 +: 8];
      for (int k = 7; k >= 0; k--) begin
        fb = c[31] ^ b[k];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [191:0] check_str();
    logic [191:0] d;
    d = '0;
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'h31 + 8'(i);
    return d;
  endfunction

  // Scoreboard for the byte-wide instance
  always @(negedge clk) begin
    if (bus8.axiov === 1'b1) begin
      exp_t e;
      pc8.push_back(cyc);
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut8_unexpected_axiov: got 1, expected 0");
      end else begin
        e = q8.pop_front();
        chk("dut8_axiod",  bus8.axiod, e.crc);
        chk("dut8_axiol",  32'(bus8.axiol), 32'(e.len));
        chk("dut8_fcs_ok", 32'(bus8.fcs_ok), 32'(e.fcs));
      end
    end
  end

  // Scoreboard for the dibit instance
  always @(negedge clk) begin
    if (bus2.axiov === 1'b1) begin
      exp_t e;
      pulses2++;
      if (q2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut2_unexpected_axiov: got 1, expected 0");
      end else begin
        e = q2.pop_front();
        chk("dut2_axiod",  bus2.axiod, e.crc);
        chk("dut2_axiol",  32'(bus2.axiol), 32'(e.len));
        chk("dut2_fcs_ok", 32'(bus2.fcs_ok), 32'(e.fcs));
      end
    end
  end

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus8.axiiv = 1'b0;
      bus8.axiil = 1'b0;
    end
  endtask

  // Drive one frame on dut8 with no trailing idle; expectation queued with the last beat
  task automatic send8(input logic [191:0] d, input int n, input exp_t e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus8.axiiv = 1'b1;
      bus8.axiid = rev8(d[i*8 +: 8]);
      bus8.axiil = (i == n - 1);
      if (i == n - 1) q8.push_back(e);
    end
  endtask

  task automatic drain8();
    int k;
    k = 0;
    while (q8.size() != 0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    if (q8.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL dut8_timeout: got %0d pending, expected 0", q8.size());
      q8.delete();
    end
  endtask

  initial begin
    logic [191:0] d;
    logic [31:0]  r;
    exp_t         e;
    int           k;
    int           p0;
    logic [7:0]   b;

    rst = 1'b1;
    bus8.axiiv = 1'b0; bus8.axiid = '0; bus8.axiil = 1'b0;
    bus2.axiiv = 1'b0; bus2.axiid = '0; bus2.axiil = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_axiov8",  32'(bus8.axiov), 32'h0);
    chk("reset_axiod8",  bus8.axiod, 32'h0);
    chk("reset_axiol8",  32'(bus8.axiol), 32'h0);
    chk("reset_fcs_ok8", 32'(bus8.fcs_ok), 32'h0);
    chk("reset_axiod2",  bus2.axiod, 32'h0);
    chk("reset_axiol2",  32'(bus2.axiol), 32'h0);
    rst = 1'b0;

    // Vector table
    d = check_str();
    vecs[0] = '{d, 9, 1'b0, CHECK, 16'd9, 1'b0};
    d[9*8 +: 32] = {8'h18, 8'h19, 8'h89, 8'hFC};
    vecs[1] = '{d, 13, 1'b0, 32'h38FB_2284, 16'd13, 1'b1};
    d[0 +: 8] = d[0 +: 8] ^ 8'h04;
    vecs[2] = '{d, 13, 1'b1, 32'h0, 16'd13, 1'b0};
    d = '0;
    d[0 +: 8] = 8'hA5;
    vecs[3] = '{d, 1, 1'b1, 32'h0, 16'd1, 1'b0};
    for (int i = 0; i < 20; i++) d[i*8 +: 8] = 8'(i * 37 + 5);
    vecs[4] = '{d, 20, 1'b1, 32'h0, 16'd15, 1'b0};

    for (int v = 0; v < 5; v++) begin
      r = model_reg(vecs[v].data, vecs[v].nbytes);
      e.crc = vecs[v].use_model ? ~r : vecs[v].crc;
      e.len = vecs[v].len;
      e.fcs = EXP_CHK & vecs[v].fcs;
      send8(vecs[v].data, vecs[v].nbytes, e);
      idle8(1);
      drain8();
      idle8(3);
      chk("hold_axiod", bus8.axiod, e.crc);
      chk("hold_axiov", 32'(bus8.axiov), 32'h0);
    end

    // Back-to-back frames with zero gap: pulses 9 cycles apart
    pc8.delete();
    e = '{CHECK, 16'd9, 1'b0};
    send8(check_str(), 9, e);
    send8(check_str(), 9, e);
    idle8(1);
    drain8();
    idle8(2);
    chk("b2b_pulses", 32'(pc8.size()), 32'd2);
    if (pc8.size() == 2) chk("b2b_spacing", 32'(pc8[1] - pc8[0]), 32'd9);

    // Dibit frame with random gaps; axiil toggles while idle and must be ignored
    p0 = pulses2;
    d = check_str();
    for (int i = 0; i < 9; i++) begin
      b = d[i*8 +: 8];
      for (int j = 0; j < 4; j++) begin
        k = $urandom_range(0, 2);
        for (int g = 0; g < k; g++) begin
          @(negedge clk);
          bus2.axiiv = 1'b0;
          bus2.axiid = 2'($urandom);
          bus2.axiil = 1'($urandom);
        end
        @(negedge clk);
        bus2.axiiv = 1'b1;
        bus2.axiid = {b[6-2*j], b[7-2*j]};
        bus2.axiil = (i == 8 && j == 3);
        if (i == 8 && j == 3) q2.push_back('{CHECK, 16'd36, 1'b0});
      end
    end
    @(negedge clk);
    bus2.axiiv = 1'b0;
    bus2.axiil = 1'b0;
    k = 0;
    while (q2.size() != 0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    if (q2.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL dut2_timeout: got %0d pending, expected 0", q2.size());
      q2.delete();
    end
    idle8(4);
    chk("dut2_pulse_count", 32'(pulses2 - p0), 32'd1);

    // Reset mid-frame, with a last beat presented during reset that must be dropped
    d = check_str();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.axiiv = 1'b1;
      bus8.axiid = rev8(d[i*8 +: 8]);
      bus8.axiil = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    bus8.axiid = 8'h5A;
    bus8.axiil = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus8.axiiv = 1'b0;
    bus8.axiil = 1'b0;
    chk("rst_axiov", 32'(bus8.axiov), 32'h0);
    chk("rst_axiod", bus8.axiod, 32'h0);
    chk("rst_axiol", 32'(bus8.axiol), 32'h0);
    chk("rst_fcs_ok", 32'(bus8.fcs_ok), 32'h0);
    idle8(2);
    chk("rst_axiod_held", bus8.axiod, 32'h0);
    send8(check_str(), 9, '{CHECK, 16'd9, 1'b0});
    idle8(1);
    drain8();
    idle8(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
# crc32_stream

Parametrised, frame-aware CRC-32 engine for the Ethernet interface: CRC-32/BZIP2 arithmetic (poly 0x04C11DB7, init 0xFFFFFFFF, output inverted) over a DATA_W-bit-per-beat stream. It replaces the fixed 2-bit RMII checksum engine. It sits beside the MAC receive and transmit paths and delimits frames with a last-beat strobe. At each frame end it presents the final CRC, the frame length, and optionally a pass/fail FCS check, then re-arms itself for the next frame.

## Interface
- DATA_W, 2, bits consumed per beat; legal values 1, 2, 4, 8.
- LEN_W, 16, width of the beat counter.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- axiiv  input  1  input beat valid.
- axiid  input  DATA_W  beat data; axiid[0] is processed first, then axiid[1], and so on.
- axiil  input  1  last beat of frame; qualified by axiiv.
- axiov  output  1  one-cycle pulse: frame result valid.
- axiod  output  32  final CRC (inverted register), held until the next result.
- axiol  output  LEN_W  frame length in beats, including the last beat, held with axiod.
- fcs_ok  output  1  FCS check result, valid while axiov is high and held with axiod.

## Operation
- Internal register crc starts at 0xFFFFFFFF.
- Each accepted beat (axiiv=1) applies DATA_W serial steps, MSB-first left shift: fb = crc[31] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0). Bits are taken in the order axiid[0..DATA_W-1].
- Beats with axiiv=0 leave crc and the counter unchanged. axiil is ignored when axiiv=0.
- State ACCUM (cnt ≠ 0) vs IDLE (cnt = 0) is implicit in the counter. No other FSM state exists.
- Accepted beat with axiil=0: crc updated and cnt incremented. cnt saturates at 2^LEN_W−1 and does not wrap.
- Accepted beat with axiil=1:
  - crc_next is computed including this beat.
  - Next cycle: axiov=1, axiod=~crc_next, axiol=sat(cnt+1), fcs_ok=(crc_next==32'hC704DD7B).
  - crc reloads 0xFFFFFFFF and cnt clears in the same edge.
- Single-beat frames (axiil on the first beat) are legal; axiol=1.
- Back-to-back frames need no gap: a beat in the cycle after a last beat starts the new frame from INIT.
- rst (any time, including mid-frame): crc=0xFFFFFFFF, cnt=0, axiov=0, axiod=0, axiol=0, fcs_ok=0. The partial frame is discarded.
- rst and axiiv in the same cycle: reset wins and the beat is dropped.

## Timing
- Input: no backpressure; one beat is accepted every cycle axiiv=1.
- Result latency: exactly 1 cycle after the last beat (registered outputs).
- axiov is high for exactly one cycle per frame. axiod, axiol and fcs_ok remain stable until the next axiov or rst.
- Per-beat next-state logic is a DATA_W-deep XOR network, fully combinational within one cycle.

## Configuration
- CRC32_STREAM_CHECK_EN defined: the residue comparator is built and fcs_ok behaves as described in Operation.
- CRC32_STREAM_CHECK_EN undefined: the comparator is omitted, fcs_ok is tied to 0, and all other behaviour is identical.

## Structure
- Package crc32_pkg holds:
  - CRC32_POLY = 32'h04C11DB7
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE = 32'hC704DD7B
  - function crc32_bit(crc, bit), one serial step.
- Sub-module crc32_comb (parameter DATA_W): purely combinational, crc_in + data → crc_out, unrolled over crc32_bit.
- crc32_stream owns the register, the counter, the output registers and the optional comparator.

## Test plan
- ASCII "123456789", each byte bit 7 first, DATA_W=8 (bit-reversed bytes on axiid), axiil on the 9th beat -> next cycle axiov=1, axiod=0xFC891918, axiol=9.
- Same string at DATA_W=2 (4 beats per byte, axiid[0]=b7, axiid[1]=b6), with random axiiv gaps -> axiod=0xFC891918, axiol=36, exactly one axiov pulse.
- With CRC32_STREAM_CHECK_EN, DATA_W=8: "123456789" followed by FCS 0xFC891918 sent MSB first -> fcs_ok=1. Same frame with one payload bit flipped -> fcs_ok=0. Without the macro -> fcs_ok=0 in both cases.
- Two frames back-to-back with zero gap, each "123456789" -> two axiov pulses 9 cycles apart, both axiod=0xFC891918.
- rst asserted after 5 beats of a frame, then a full "123456789" frame sent -> outputs zero through the reset, then axiod=0xFC891918, axiol=9.
- LEN_W=4, 20-beat frame with axiil on beat 20 -> axiol=15 (saturated); the CRC equals a reference model computed over all 20 beats.
